// File: rtl/rf_hazard_scoreboard_pkg.sv
// Shared constants and bus payload types for the register-file hazard scoreboard.
// Holds the NREG/AW/CNT_W defaults and the widths of an optional bundled
// ID/WB scoreboard bus.
package rf_hazard_scoreboard_pkg;

    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned CNT_W_DEF = 2;

    // ID-side request as it would travel on a bundled bus
    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [AW_DEF-1:0] rs1;
        logic              rs1_used;
        logic [AW_DEF-1:0] rs2;
        logic              rs2_used;
        logic [AW_DEF-1:0] rd;
        logic              rd_we;
        logic              csr_rd;
        logic              csr_we;
    } id_bus_t;

    // WB-side retire as it would travel on a bundled bus
    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] rd;
        logic              rd_we;
        logic              csr_we;
    } wb_bus_t;

    localparam int unsigned ID_BUS_W = $bits(id_bus_t);
    localparam int unsigned WB_BUS_W = $bits(wb_bus_t);

endpackage

// File: rtl/rf_hazard_scoreboard_if.sv
// ID/WB handshake bundle between the decode/writeback stages and the scoreboard.
// master: pipeline side (drives ID and WB fields, receives stall/fire).
// slave : scoreboard side.
interface rf_hazard_scoreboard_if
    import rf_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
);
    logic          id_valid_i;
    logic          id_ready_i;
    logic [AW-1:0] id_rs1_i;
    logic [AW-1:0] id_rs2_i;
    logic          id_rs1_used_i;
    logic          id_rs2_used_i;
    logic [AW-1:0] id_rd_i;
    logic          id_rd_we_i;
    logic          id_csr_rd_i;
    logic          id_csr_we_i;
    logic          wb_valid_i;
    logic [AW-1:0] wb_rd_i;
    logic          wb_rd_we_i;
    logic          wb_csr_we_i;
    logic          id_stall_o;
    logic          issue_fire_o;

    modport master (
        output id_valid_i, id_ready_i, id_rs1_i, id_rs2_i, id_rs1_used_i,
               id_rs2_used_i, id_rd_i, id_rd_we_i, id_csr_rd_i, id_csr_we_i,
               wb_valid_i, wb_rd_i, wb_rd_we_i, wb_csr_we_i,
        input  id_stall_o, issue_fire_o
    );

    modport slave (
        input  id_valid_i, id_ready_i, id_rs1_i, id_rs2_i, id_rs1_used_i,
               id_rs2_used_i, id_rd_i, id_rd_we_i, id_csr_rd_i, id_csr_we_i,
               wb_valid_i, wb_rd_i, wb_rd_we_i, wb_csr_we_i,
        output id_stall_o, issue_fire_o
    );

endinterface

// File: rtl/rf_hazard_scoreboard_sb_counter.sv
// sb_counter: saturating up/down in-flight write counter with synchronous clear.
// Ports: clk, rst_n (async active-low), inc_i, dec_i, clr_i,
//        zero_o / max_o (decoded from the held count),
//        underflow_c_o (combinational: a decrement hit an empty counter).
module sb_counter
    import rf_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic zero_o,
    output logic max_o,
    output logic underflow_c_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign zero_o = (cnt_q == '0);
    assign max_o  = (cnt_q == CNT_MAX);

    // Simultaneous inc+dec cancel; a flush makes the same-cycle retire irrelevant
    assign underflow_c_o = dec_i & ~inc_i & ~clr_i & zero_o;

    // Next count: clear wins, then net increment/decrement with hold at the rails
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && !max_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rf_hazard_scoreboard.sv
// rf_hazard_scoreboard: issue-stage scoreboard tracking in-flight GPR/CSR writes
// and producing ID back-pressure. Never touches register data.
// Ports: clk, rst_n (async active-low); sb_if (slave) carries ID/WB fields and
//        id_stall_o / issue_fire_o (combinational); flush_i; busy_vec_o (one
//        bit per GPR, bit 0 always 0); underflow_err_o (sticky until reset).
// Build option: define CSR_SCOREBOARD_EN to track CSR writes; otherwise the CSR
//        fields are ignored and CSR ordering relies on serialising CSR ops.
module rf_hazard_scoreboard
    import rf_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREG  = NREG_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rf_hazard_scoreboard_if.slave   sb_if,
    input  logic                    flush_i,
    output logic [NREG-1:0]         busy_vec_o,
    output logic                    underflow_err_o
);

    logic [NREG-1:0] zero_vec;
    logic [NREG-1:0] max_vec;
    logic [NREG-1:1] uf_vec;
    logic [NREG-1:1] inc_vec;
    logic [NREG-1:1] dec_vec;
    logic            issue_fire;
    logic            stall;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            waw_full;
    logic            csr_haz;
    logic            csr_uf;
    logic            underflow_err_q;
    logic            underflow_err_d;

    // r0 is never tracked: always reads as empty and never full
    assign zero_vec[0] = 1'b1;
    assign max_vec[0]  = 1'b0;

    // Hazards look only at registered counts; no bypass of this cycle's retire
    assign rs1_haz  = sb_if.id_rs1_used_i & (sb_if.id_rs1_i != '0) & ~zero_vec[sb_if.id_rs1_i];
    assign rs2_haz  = sb_if.id_rs2_used_i & (sb_if.id_rs2_i != '0) & ~zero_vec[sb_if.id_rs2_i];
    assign waw_full = sb_if.id_rd_we_i & (sb_if.id_rd_i != '0) & max_vec[sb_if.id_rd_i];

    assign stall      = sb_if.id_valid_i & (rs1_haz | rs2_haz | waw_full | csr_haz);
    assign issue_fire = sb_if.id_valid_i & sb_if.id_ready_i & ~stall & ~flush_i;

    assign sb_if.id_stall_o   = stall;
    assign sb_if.issue_fire_o = issue_fire;

    // Per-register increment/decrement decode
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (issue_fire && sb_if.id_rd_we_i && (sb_if.id_rd_i == AW'(i))) begin
                inc_vec[i] = 1'b1;
            end
            if (sb_if.wb_valid_i && sb_if.wb_rd_we_i && (sb_if.wb_rd_i == AW'(i))) begin
                dec_vec[i] = 1'b1;
            end
        end
    end

    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk           (clk),
            .rst_n         (rst_n),
            .inc_i         (inc_vec[gi]),
            .dec_i         (dec_vec[gi]),
            .clr_i         (flush_i),
            .zero_o        (zero_vec[gi]),
            .max_o         (max_vec[gi]),
            .underflow_c_o (uf_vec[gi])
        );
    end

`ifdef CSR_SCOREBOARD_EN
    logic csr_zero;
    logic csr_max;

    sb_counter #(.CNT_W(CNT_W)) u_csr_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc_i         (issue_fire & sb_if.id_csr_we_i),
        .dec_i         (sb_if.wb_valid_i & sb_if.wb_csr_we_i),
        .clr_i         (flush_i),
        .zero_o        (csr_zero),
        .max_o         (csr_max),
        .underflow_c_o (csr_uf)
    );

    assign csr_haz = (sb_if.id_csr_rd_i & ~csr_zero) | (sb_if.id_csr_we_i & csr_max);
`else
    logic unused_csr;

    assign csr_haz    = 1'b0;
    assign csr_uf     = 1'b0;
    assign unused_csr = ^{sb_if.id_csr_rd_i, sb_if.id_csr_we_i, sb_if.wb_csr_we_i};
`endif

    // Sticky underflow: survives flush, cleared only by reset
    assign underflow_err_d = underflow_err_q | (|uf_vec) | csr_uf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_err_q <= 1'b0;
        end else begin
            underflow_err_q <= underflow_err_d;
        end
    end

    assign busy_vec_o      = ~zero_vec;
    assign underflow_err_o = underflow_err_q;

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// Directed scoreboard bench for rf_hazard_scoreboard: each stimulus step pushes
// its hand-computed expected outputs; a negedge monitor pops and compares.
module tb_rf_hazard_scoreboard;

`ifdef CSR_SCOREBOARD_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        stall;
        logic        fire;
        logic [31:0] busy;
        logic        uf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] busy_vec_o;
    logic        underflow_err_o;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    rf_hazard_scoreboard_if #(.AW(5)) sb_if ();

    rf_hazard_scoreboard #(.NREG(32), .AW(5), .CNT_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sb_if           (sb_if.slave),
        .flush_i         (flush_i),
        .busy_vec_o      (busy_vec_o),
        .underflow_err_o (underflow_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are sampled mid-cycle, after the step has driven inputs
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (sb_if.id_stall_o === e.stall && sb_if.issue_fire_o === e.fire &&
                busy_vec_o === e.busy && underflow_err_o === e.uf) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got stall=%b fire=%b busy=%h uf=%b, want stall=%b fire=%b busy=%h uf=%b",
                         e.name, sb_if.id_stall_o, sb_if.issue_fire_o, busy_vec_o, underflow_err_o,
                         e.stall, e.fire, e.busy, e.uf);
            end
        end
    end

    function automatic logic [31:0] b(input int n);
        logic [31:0] v;
        v = 32'd1 << n;
        return v;
    endfunction

    task automatic idle();
        sb_if.id_valid_i    = 1'b0;
        sb_if.id_ready_i    = 1'b0;
        sb_if.id_rs1_i      = '0;
        sb_if.id_rs2_i      = '0;
        sb_if.id_rs1_used_i = 1'b0;
        sb_if.id_rs2_used_i = 1'b0;
        sb_if.id_rd_i       = '0;
        sb_if.id_rd_we_i    = 1'b0;
        sb_if.id_csr_rd_i   = 1'b0;
        sb_if.id_csr_we_i   = 1'b0;
        sb_if.wb_valid_i    = 1'b0;
        sb_if.wb_rd_i       = '0;
        sb_if.wb_rd_we_i    = 1'b0;
        sb_if.wb_csr_we_i   = 1'b0;
        flush_i             = 1'b0;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        sb_if.id_valid_i = 1'b1;
        sb_if.id_ready_i = 1'b1;
        sb_if.id_rd_i    = rd;
        sb_if.id_rd_we_i = 1'b1;
    endtask

    task automatic issue_rd(input logic [4:0] rs1, input logic [4:0] rs2);
        sb_if.id_valid_i    = 1'b1;
        sb_if.id_ready_i    = 1'b1;
        sb_if.id_rs1_i      = rs1;
        sb_if.id_rs1_used_i = 1'b1;
        sb_if.id_rs2_i      = rs2;
        sb_if.id_rs2_used_i = 1'b1;
    endtask

    task automatic wb(input logic [4:0] rd);
        sb_if.wb_valid_i = 1'b1;
        sb_if.wb_rd_i    = rd;
        sb_if.wb_rd_we_i = 1'b1;
    endtask

    // Push expectation for the inputs currently driven, then advance one cycle
    task automatic chk(input string name, input logic stall, input logic fire,
                       input logic [31:0] busy, input logic uf);
        exp_t e;
        e.name  = name;
        e.stall = stall;
        e.fire  = fire;
        e.busy  = busy;
        e.uf    = uf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        issue_rd(5'd5, 5'd0);
        sb_if.id_ready_i = 1'b0;
        chk("reset", 1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;

        // RAW on r5: reader stalls through the WB cycle, issues the cycle after
        issue_wr(5'd5);                                  chk("wr_r5",        0, 1, 32'h0, 0);
        issue_rd(5'd5, 5'd0);                            chk("raw_r5_stall", 1, 0, b(5),  0);
        issue_rd(5'd0, 5'd5); wb(5'd5);                  chk("raw_r5_wb",    1, 0, b(5),  0);
        issue_rd(5'd5, 5'd0);                            chk("raw_r5_go",    0, 1, 32'h0, 0);

        // r0 is never tracked
        issue_wr(5'd0);                                  chk("wr_r0",        0, 1, 32'h0, 0);
        issue_rd(5'd0, 5'd0);                            chk("rd_r0",        0, 1, 32'h0, 0);

        // WAW saturation on r7
        issue_wr(5'd7);                                  chk("r7_w1",        0, 1, 32'h0, 0);
        issue_wr(5'd7);                                  chk("r7_w2",        0, 1, b(7),  0);
        issue_wr(5'd7);                                  chk("r7_w3",        0, 1, b(7),  0);
        issue_wr(5'd7);                                  chk("r7_full",      1, 0, b(7),  0);
        issue_wr(5'd7); wb(5'd7);                        chk("r7_full_wb",   1, 0, b(7),  0);
        issue_wr(5'd7);                                  chk("r7_w4",        0, 1, b(7),  0);
        wb(5'd7);                                        chk("r7_drain1",    0, 0, b(7),  0);
        wb(5'd7);                                        chk("r7_drain2",    0, 0, b(7),  0);
        wb(5'd7);                                        chk("r7_drain3",    0, 0, b(7),  0);

        // Same-register issue+retire cancels; different registers both update
        issue_wr(5'd9);                                  chk("r9_w1",        0, 1, 32'h0, 0);
        issue_wr(5'd9); wb(5'd9);                        chk("r9_wb_same",   0, 1, b(9),  0);
        issue_wr(5'd10);                                 chk("r10_w1",       0, 1, b(9),  0);
        issue_wr(5'd9); wb(5'd10);                       chk("r9_wb_r10",    0, 1, b(9) | b(10), 0);
        wb(5'd9);                                        chk("r9_drain1",    0, 0, b(9),  0);
        wb(5'd9);                                        chk("r9_drain2",    0, 0, b(9),  0);
        sb_if.id_valid_i = 1'b0;                         chk("r9_empty",     0, 0, 32'h0, 0);

        // Flush with r3 at 2 and one CSR write in flight
        issue_wr(5'd3);                                  chk("r3_w1",        0, 1, 32'h0, 0);
        issue_wr(5'd3);                                  chk("r3_w2",        0, 1, b(3),  0);
        sb_if.id_valid_i = 1'b1; sb_if.id_ready_i = 1'b1;
        sb_if.id_csr_we_i = 1'b1;                        chk("csr_w_pre",    0, 1, b(3),  0);
        issue_wr(5'd3); sb_if.id_csr_we_i = 1'b1;
        wb(5'd3); flush_i = 1'b1;                        chk("flush",        0, 0, b(3),  0);
        sb_if.id_valid_i = 1'b1; sb_if.id_ready_i = 1'b1;
        sb_if.id_csr_rd_i = 1'b1;                        chk("post_flush",   0, 1, 32'h0, 0);

        // CSR RAW, active only when CSR tracking is built in
        sb_if.id_valid_i = 1'b1; sb_if.id_ready_i = 1'b1;
        sb_if.id_csr_we_i = 1'b1;                        chk("csr_wr",       0, 1, 32'h0, 0);
        sb_if.id_valid_i = 1'b1; sb_if.id_ready_i = 1'b1;
        sb_if.id_csr_rd_i = 1'b1;                        chk("csr_rd_stall", CSR_EN, ~CSR_EN, 32'h0, 0);
        sb_if.id_valid_i = 1'b1; sb_if.id_ready_i = 1'b1;
        sb_if.id_csr_rd_i = 1'b1; sb_if.wb_valid_i = 1'b1;
        sb_if.wb_csr_we_i = 1'b1;                        chk("csr_rd_wb",    CSR_EN, ~CSR_EN, 32'h0, 0);
        sb_if.id_valid_i = 1'b1; sb_if.id_ready_i = 1'b1;
        sb_if.id_csr_rd_i = 1'b1;                        chk("csr_rd_go",    0, 1, 32'h0, 0);

        // Underflow is sticky through flush, cleared by async reset
        wb(5'd12);                                       chk("uf_wb_r12",    0, 0, 32'h0, 0);
        sb_if.id_valid_i = 1'b0;                         chk("uf_set",       0, 0, 32'h0, 1);
        flush_i = 1'b1;                                  chk("uf_flush",     0, 0, 32'h0, 1);
        issue_wr(5'd4);                                  chk("uf_r4_w",      0, 1, 32'h0, 1);
        issue_rd(5'd4, 5'd0);                            chk("uf_r4_raw",    1, 0, b(4),  1);
        issue_rd(5'd4, 5'd0); sb_if.id_ready_i = 1'b0;
        rst_n = 1'b0;                                    chk("rst_mid",      0, 0, 32'h0, 0);
        rst_n = 1'b1;
        issue_rd(5'd4, 5'd0);                            chk("after_rst",    0, 1, 32'h0, 0);

        // Bounded drain of the expectation queue
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
